// File: rtl/regs_2r1w_clr_if.sv
// Bus bundle for the 2-read/1-write register file with clear sweep.
// The master drives the write and read addresses; the slave returns read data and status.
interface regs_2r1w_clr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  i_wt_en;
    logic [ADDR_WIDTH-1:0] i_wt_addr;
    logic [DATA_WIDTH-1:0] i_wt_data;
    logic [ADDR_WIDTH-1:0] i_rd_addr_a;
    logic [DATA_WIDTH-1:0] o_rd_data_a;
    logic [ADDR_WIDTH-1:0] i_rd_addr_b;
    logic [DATA_WIDTH-1:0] o_rd_data_b;
    logic                  i_clr;
    logic                  o_busy;
    logic                  o_wt_err;

    modport master (
        output i_wt_en,
        output i_wt_addr,
        output i_wt_data,
        output i_rd_addr_a,
        output i_rd_addr_b,
        output i_clr,
        input  o_rd_data_a,
        input  o_rd_data_b,
        input  o_busy,
        input  o_wt_err
    );

    modport slave (
        input  i_wt_en,
        input  i_wt_addr,
        input  i_wt_data,
        input  i_rd_addr_a,
        input  i_rd_addr_b,
        input  i_clr,
        output o_rd_data_a,
        output o_rd_data_b,
        output o_busy,
        output o_wt_err
    );
endinterface

// File: rtl/regs_2r1w_clr.sv
// Register file with one synchronous write port and two combinational read ports.
// Adds an optional hardwired zero entry, write bypass and a hardware clear sweep.
module regs_2r1w_clr #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int ZERO_REG    = 0,
    parameter int READ_BYPASS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    regs_2r1w_clr_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  wt_err;
    logic                  clearing;
    logic                  wt_zero;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    assign clearing = (state == S_CLEAR);
    assign wt_zero  = (ZERO_REG != 0) && (bus.i_wt_addr == '0);
    assign wr_ok    = !clearing && bus.i_wt_en && !wt_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            wt_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wt_err <= bus.i_wt_en & clearing;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus.i_clr) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Storage has no reset; the sweep is what makes the contents defined.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (clearing) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                mem[bus.i_wt_addr] <= bus.i_wt_data;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] rd_pick(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] val;
        if (clearing) begin
            val = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end else if ((READ_BYPASS != 0) && bus.i_wt_en
                     && (addr == bus.i_wt_addr)) begin
            val = bus.i_wt_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    always_comb begin
        rd_a = rd_pick(bus.i_rd_addr_a, mem[bus.i_rd_addr_a]);
    end

    always_comb begin
        rd_b = rd_pick(bus.i_rd_addr_b, mem[bus.i_rd_addr_b]);
    end

    assign bus.o_rd_data_a = rd_a;
    assign bus.o_rd_data_b = rd_b;
    assign bus.o_busy      = clearing;
    assign bus.o_wt_err    = wt_err;
endmodule
